// File: rtl/iter_shifter.sv
// Multi-cycle logical shifter: walks a 32-bit operand left or right by 0..31
// bits using one 5-bit or 1-bit step per cycle, behind a start/busy/done handshake.
`timescale 1ns/1ps
module iter_shifter #(
    parameter int n  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [n-1:0]  num,
    input  logic [SW-1:0] shamt,
    input  logic          dir,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SW-1:0] BIG_STEP = SW'(5);

    state_t        state_q;
    logic [n-1:0]  acc_q, acc_d;
    logic [n-1:0]  result_q;
    logic [SW-1:0] rem_q, rem_d;
    logic          dr_q;
    logic          busy_q;
    logic          done_q;

    // One step of the shift walk: take the big step while at least 5 bits
    // remain, otherwise finish with single-bit steps.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        acc_d = acc_q;
        rem_d = rem_q;
        if (rem_q >= BIG_STEP) begin
            acc_d = dr_q ? (acc_q >> 5) : (acc_q << 5);
            rem_d = rem_q - BIG_STEP;
        end else if (rem_q != '0) begin
            acc_d = dr_q ? (acc_q >> 1) : (acc_q << 1);
            rem_d = rem_q - SW'(1);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            dr_q     <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= num;
                        rem_q   <= shamt;
                        dr_q    <= dir;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem_q == '0) begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter: latency, result, busy/done
// handshake, ignored starts, back-to-back requests and mid-operation reset.
`timescale 1ns/1ps
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run;
    int tests_failed;

    iter_shifter #(.n(32), .SW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num    (num),
        .shamt  (shamt),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, then watch a fixed 40-cycle window (cycle c = sample
    // #1 after the c-th edge following the accepting edge).
    task automatic do_op(input logic [31:0] a, input logic [4:0] s, input logic d,
                         output int lat, output logic [31:0] res,
                         output int done_cnt, output int busy_cnt);
        @(negedge clk);
        num = a; shamt = s; dir = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num = ~a; shamt = ~s; dir = ~d;
        lat = -1; res = 32'hx; done_cnt = 0;
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = c;
                    res = result;
                end
            end
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [4:0] s,
                            input logic d, input logic [31:0] exp_res, input int exp_lat);
        int lat, done_cnt, busy_cnt;
        logic [31:0] res;
        do_op(a, s, d, lat, res, done_cnt, busy_cnt);
        tests_run++;
        if (res !== exp_res) begin
            tests_failed++;
            $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt);
        end
        tests_run++;
        if (busy_cnt !== exp_lat + 1) begin
            tests_failed++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_lat + 1);
        end
        tests_run++;
        if (result !== exp_res) begin
            tests_failed++;
            $display("FAIL %s result hold: got %h expected %h", name, result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num = 32'h0; shamt = 5'd0; dir = 1'b0;
        #23;
        tests_run++;
        if ({busy, done, result} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0/0/0",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, done, result} !== 34'h0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b done=%b result=%h expected 0/0/0",
                     busy, done, result);
        end
    endtask

    task automatic test_left_shift();
        check_op("left_5",     32'h00000001, 5'd5,  1'b0, 32'h00000020, 2);
        check_op("left_31",    32'hFFFFFFFF, 5'd31, 1'b0, 32'h80000000, 8);
        check_op("left_4",     32'hDEADBEEF, 5'd4,  1'b0, 32'hEADBEEF0, 5);
    endtask

    task automatic test_zero_shift();
        check_op("zero_shamt", 32'h13579BDF, 5'd0,  1'b0, 32'h13579BDF, 1);
    endtask

    task automatic test_right_shift();
        check_op("right_7",    32'hF0000000, 5'd7,  1'b1, 32'h01E00000, 4);
        check_op("right_10",   32'h12345678, 5'd10, 1'b1, 32'h00048D15, 3);
        check_op("right_31",   32'h80000000, 5'd31, 1'b1, 32'h00000001, 8);
    endtask

    task automatic test_ignore_start();
        int done_cnt, lat;
        logic [31:0] res;
        @(negedge clk);
        num = 32'h1; shamt = 5'd5; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0; lat = -1; res = 32'hx;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                num = 32'hBEEF; shamt = 5'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin lat = c; res = result; end
            end
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL ignore_start done pulses: got %0d expected 1", done_cnt);
        end
        tests_run++;
        if (res !== 32'h20 || lat !== 2) begin
            tests_failed++;
            $display("FAIL ignore_start op: got result=%h lat=%0d expected 00000020/2", res, lat);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int first_c, second_c, done_cnt;
        logic [31:0] r1, r2;
        @(negedge clk);
        num = 32'hCAFEF00D; shamt = 5'd0; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        num = 32'h1; shamt = 5'd1; dir = 1'b0;
        first_c = -1; second_c = -1; done_cnt = 0; r1 = 32'hx; r2 = 32'hx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 3) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_c < 0) begin first_c = c; r1 = result; end
                else if (second_c < 0) begin second_c = c; r2 = result; end
            end
        end
        tests_run++;
        if (first_c !== 1 || r1 !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL b2b first: got cycle=%0d result=%h expected 1/cafef00d", first_c, r1);
        end
        tests_run++;
        if (second_c !== 5 || r2 !== 32'h2) begin
            tests_failed++;
            $display("FAIL b2b second: got cycle=%0d result=%h expected 5/00000002", second_c, r2);
        end
        tests_run++;
        if (done_cnt !== 2) begin
            tests_failed++;
            $display("FAIL b2b done pulses: got %0d expected 2", done_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        @(negedge clk);
        num = 32'hFFFFFFFF; shamt = 5'd31; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: got busy=%b done=%b result=%h expected 0/0/0",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_abort done pulses: got %0d expected 0", done_cnt);
        end
        check_op("after_reset", 32'h1, 5'd1, 1'b0, 32'h2, 2);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_left_shift();
        test_zero_shift();
        test_right_shift();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
